// File: rtl/lmsm_sequencer.sv
// lmsm_sequencer: walks an LM/SM register-list mask and issues one register-index/memory-address
// step for each set bit, using a valid/ready handshake toward the datapath. Clear bits are
// skipped and cost no cycles. done pulses for one cycle when the list has been used up.
//
// Build option: define LMSM_DESCEND_EN to walk from the highest set bit downward and decrement
// the address on each step. By default the walk runs from the lowest set bit upward and the
// address increments. Handshake, timing and done behaviour are the same in both builds.
//
// state  | meaning
// IDLE   | waiting for start; captures operands when start is seen
// XFER   | presenting reg_idx/mem_addr; advances on step_ready
// DONE   | one-cycle done pulse, then back to IDLE

module lmsm_sequencer #(
   parameter int NREG = 8,
   parameter int IDXW = 3,
   parameter int AW   = 16
) (
   input  logic            lmsm_clock,
   input  logic            lmsm_reset_n,
   input  logic            start,
   input  logic            is_store,
   input  logic [NREG-1:0] reg_list,
   input  logic [AW-1:0]   base_addr,
   input  logic            step_ready,
   output logic            step_valid,
   output logic [IDXW-1:0] reg_idx,
   output logic [AW-1:0]   mem_addr,
   output logic            rf_wr_en,
   output logic            mem_wr_en,
   output logic            busy,
   output logic            done,
   output logic [IDXW:0]   xfer_count
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_XFER = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t          state_q, state_d;
   logic [NREG-1:0] mask_q, mask_d;
   logic [AW-1:0]   addr_q, addr_d;
   logic            store_q, store_d;
   logic [IDXW:0]   xfer_count_q, xfer_count_d;

   logic [IDXW-1:0] sel_idx;
   logic [NREG-1:0] sel_oh;

   // Pick the next register: the priority bit of the remaining mask
   always_comb begin
      sel_idx = '0;
`ifdef LMSM_DESCEND_EN
      for (int i = 0; i < NREG; i++) begin
         if (mask_q[i]) sel_idx = IDXW'(i);
      end
`else
      for (int i = NREG - 1; i >= 0; i--) begin
         if (mask_q[i]) sel_idx = IDXW'(i);
      end
`endif
      sel_oh = NREG'(1) << sel_idx;
   end

   // Next-state and datapath update for the sequencing FSM
   always_comb begin
      state_d      = state_q;
      mask_d       = mask_q;
      addr_d       = addr_q;
      store_d      = store_q;
      xfer_count_d = xfer_count_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               mask_d       = reg_list;
               addr_d       = base_addr;
               store_d      = is_store;
               xfer_count_d = '0;
               state_d      = (reg_list != '0) ? S_XFER : S_DONE;
            end
         end
         S_XFER: begin
            // A stalled step keeps every register untouched, so outputs stay stable.
            if (step_ready) begin
               mask_d       = mask_q & ~sel_oh;
`ifdef LMSM_DESCEND_EN
               addr_d       = addr_q - AW'(1);
`else
               addr_d       = addr_q + AW'(1);
`endif
               xfer_count_d = xfer_count_q + (IDXW+1)'(1);
               if (mask_d == '0) state_d = S_DONE;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State and captured-operand registers with synchronous active-low reset
   always_ff @(posedge lmsm_clock) begin
      if (!lmsm_reset_n) begin
         state_q      <= S_IDLE;
         mask_q       <= '0;
         addr_q       <= '0;
         store_q      <= 1'b0;
         xfer_count_q <= '0;
      end else begin
         state_q      <= state_d;
         mask_q       <= mask_d;
         addr_q       <= addr_d;
         store_q      <= store_d;
         xfer_count_q <= xfer_count_d;
      end
   end

   // Outputs decode straight from the state register; the index and address read as zero
   // outside XFER so that an idle sequencer shows nothing on the step bus.
   assign step_valid = (state_q == S_XFER);
   assign done       = (state_q == S_DONE);
   assign busy       = step_valid | done;
   assign reg_idx    = step_valid ? sel_idx : '0;
   assign mem_addr   = step_valid ? addr_q : '0;
   assign rf_wr_en   = step_valid & ~store_q;
   assign mem_wr_en  = step_valid & store_q;
   assign xfer_count = xfer_count_q;

endmodule
